aes128_ks_ctrl: RTL and testbench

Sequencing controller for the masked AES-128 key-schedule datapath (4 shared S-boxes, rcon unit, per-round XOR chain). Loads a shared 128-bit key into the round-key register and steps the datapath through 10 expansion rounds. It drives the S-box feed gate, the rcon update/reset, the key-register enable and select, and randomness-request strobes. Each round key 0..10 is delivered to the cipher core over a valid/ready handshake.

---
 rtl/aes_ks_pkg.sv | 16 +
 rtl/ks_lat_counter.sv | 34 +++
 rtl/aes128_ks_ctrl.sv | 120 ++++++++++++
 tb/tb_aes128_ks_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ks_pkg.sv
// Shared definitions for the masked AES-128 key-schedule controllers.
package aes_ks_pkg;

  typedef enum logic [2:0] {
    KsIdle = 3'd0,
    KsLoad = 3'd1,
    KsFeed = 3'd2,
    KsWait = 3'd3,
    KsUpd  = 3'd4,
    KsHold = 3'd5
  } ks_state_t;

  localparam int unsigned AES128_NROUNDS = 10;
  localparam logic [7:0]  RCON_INIT      = 8'h01;

endpackage

// File: rtl/ks_lat_counter.sv
// Loadable down-counter that flags when one cycle of latency remains.
module ks_lat_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             term_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == Width'(1));

endmodule

// File: rtl/aes128_ks_ctrl.sv
// Sequencer for the masked AES-128 key schedule: loads a key, then steps 10 expansion
// rounds, presenting each round key over a valid/ready handshake.
module aes128_ks_ctrl
  import aes_ks_pkg::*;
#(
  parameter int unsigned SB_LAT  = 4,
  parameter int unsigned NROUNDS = AES128_NROUNDS
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       key_sel_o,
  output logic       key_reg_en_o,
  output logic       data_in_valid_o,
  output logic       rcon_rst_o,
  output logic       rcon_update_o,
  output logic       rnd_req_o,
  output logic       rk_valid_o,
  input  logic       rk_ready_i,
  output logic [3:0] rk_idx_o,
  output logic       rk_last_o,
  output logic       busy_o
);

  localparam logic [2:0] StIdle = KsIdle;
  localparam logic [2:0] StLoad = KsLoad;
  localparam logic [2:0] StFeed = KsFeed;
  localparam logic [2:0] StWait = KsWait;
  localparam logic [2:0] StUpd  = KsUpd;
  localparam logic [2:0] StHold = KsHold;

  localparam int unsigned  CntW      = $clog2(SB_LAT + 1);
  localparam logic [CntW-1:0] WaitInit = CntW'(SB_LAT - 1);
  localparam logic [3:0]   LastRound = 4'(NROUNDS);

  logic [2:0] state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       lat_term;

  ks_lat_counter #(
    .Width(CntW)
  ) u_lat_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (state_q == StFeed),
    .load_val_i(WaitInit),
    .dec_i     (state_q == StWait),
    .term_o    (lat_term)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      StIdle: if (in_valid_i) state_d = StLoad;
      StLoad: begin
        round_d = '0;
        state_d = StHold;
      end
      StHold: if (rk_ready_i) state_d = (round_q == LastRound) ? StIdle : StFeed;
      StFeed: state_d = (SB_LAT > 1) ? StWait : StUpd;
      StWait: if (lat_term) state_d = StUpd;
      StUpd: begin
        round_d = round_q + 4'd1;
        state_d = StHold;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Key register and rcon only move in LOAD/UPD, so both stay frozen while the S-boxes work.
  always_comb begin
    in_ready_o      = 1'b0;
    key_sel_o       = 1'b0;
    key_reg_en_o    = 1'b0;
    data_in_valid_o = 1'b0;
    rcon_rst_o      = 1'b0;
    rcon_update_o   = 1'b0;
    rnd_req_o       = 1'b0;
    rk_valid_o      = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        rcon_rst_o = 1'b1;
      end
      StLoad: begin
        key_reg_en_o = 1'b1;
        rcon_rst_o   = 1'b1;
      end
      StHold: rk_valid_o = 1'b1;
      StFeed: begin
        data_in_valid_o = 1'b1;
        rnd_req_o       = 1'b1;
      end
      StWait: rnd_req_o = 1'b1;
      StUpd: begin
        key_sel_o     = 1'b1;
        key_reg_en_o  = 1'b1;
        rcon_update_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rk_idx_o  = round_q;
  assign rk_last_o = rk_valid_o && (round_q == LastRound);
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_aes128_ks_ctrl.sv
// Bench for aes128_ks_ctrl: directed vectors, FIPS-197 schedule through a behavioural
// datapath, stall/reset sequences and randomized traffic against a timing model.
module tb_aes128_ks_ctrl;

  localparam int N = 10;
  localparam int L = 4;
  localparam int MIdle = 0, MLoad = 1, MHold = 2, MRun = 3;

  localparam logic [9:0] FIdle = 10'b1000100000;
  localparam logic [9:0] FLoad = 10'b0010100001;
  localparam logic [9:0] FHold = 10'b0000000101;
  localparam logic [9:0] FFeed = 10'b0001001001;
  localparam logic [9:0] FWait = 10'b0000001001;
  localparam logic [9:0] FUpd  = 10'b0110010001;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Rk1     = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Rk10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst, in_valid, rk_ready;
  always #5 clk = ~clk;

  logic [2:0] x_in_ready, x_key_sel, x_key_reg_en, x_div, x_rcon_rst, x_rcon_upd;
  logic [2:0] x_rnd, x_rk_valid, x_rk_last, x_busy;
  logic [3:0] x_rk_idx [3];

  // Instance 1 (SB_LAT=4) is fully modelled; instances 0 and 2 cover the latency sweep.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes128_ks_ctrl #(
      .SB_LAT (g == 0 ? 1 : (g == 1 ? 4 : 6)),
      .NROUNDS(N)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .in_valid_i     (in_valid),
      .in_ready_o     (x_in_ready[g]),
      .key_sel_o      (x_key_sel[g]),
      .key_reg_en_o   (x_key_reg_en[g]),
      .data_in_valid_o(x_div[g]),
      .rcon_rst_o     (x_rcon_rst[g]),
      .rcon_update_o  (x_rcon_upd[g]),
      .rnd_req_o      (x_rnd[g]),
      .rk_valid_o     (x_rk_valid[g]),
      .rk_ready_i     (rk_ready),
      .rk_idx_o       (x_rk_idx[g]),
      .rk_last_o      (x_rk_last[g]),
      .busy_o         (x_busy[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;
  int m_st, m_k, m_round;
  int gap [3];
  int rcnt [3];
  bit armed [3];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Unmasked stand-in for the key-schedule datapath, steered by the controller under test.
  logic [127:0] ext_key, key_reg;
  logic [7:0]   rcon;
  always_ff @(posedge clk) begin
    if (x_rcon_rst[1]) rcon <= 8'h01;
    else if (x_rcon_upd[1]) rcon <= xt(rcon);
    if (x_key_reg_en[1]) key_reg <= x_key_sel[1] ? expand(key_reg, rcon) : ext_key;
  end

  function automatic logic [13:0] dut_vec();
    return {x_in_ready[1], x_key_sel[1], x_key_reg_en[1], x_div[1], x_rcon_rst[1],
            x_rcon_upd[1], x_rnd[1], x_rk_valid[1], x_rk_last[1], x_busy[1], x_rk_idx[1]};
  endfunction

  // Expected outputs from time since the last handshake: feed at 1, randomness for L cycles,
  // update L cycles after the feed.
  function automatic logic [13:0] model_vec();
    logic [9:0] f;
    f = '0;
    case (m_st)
      MIdle: f = FIdle;
      MLoad: f = FLoad;
      MHold: f = FHold | ((m_round == N) ? 10'b0000000010 : 10'b0);
      default: begin
        f[0] = 1'b1;
        f[6] = (m_k == 1);
        f[3] = (m_k <= L);
        if (m_k == L + 1) begin
          f[8] = 1'b1;
          f[7] = 1'b1;
          f[4] = 1'b1;
        end
      end
    endcase
    return {f, 4'(m_round)};
  endfunction

  task automatic model_step(input logic r, input logic iv, input logic rr);
    if (r) begin
      m_st = MIdle;
      m_round = 0;
      m_k = 0;
    end else begin
      case (m_st)
        MIdle: if (iv) m_st = MLoad;
        MLoad: begin
          m_round = 0;
          m_st = MHold;
        end
        MHold: if (rr) begin
          if (m_round == N) m_st = MIdle;
          else begin
            m_st = MRun;
            m_k = 1;
          end
        end
        default: if (m_k == L + 1) begin
          m_round++;
          m_st = MHold;
        end else m_k++;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic lat_mon(input int i);
    int lat;
    lat = (i == 0) ? 1 : ((i == 1) ? 4 : 6);
    if (x_div[i]) begin
      gap[i] = 0;
      rcnt[i] = 0;
      armed[i] = 1'b1;
    end else gap[i]++;
    if (x_rnd[i]) rcnt[i]++;
    if (x_rcon_upd[i] && armed[i]) begin
      check($sformatf("feed_to_upd_%0d", lat), 128'(gap[i]), 128'(lat));
      check($sformatf("rnd_req_cnt_%0d", lat), 128'(rcnt[i]), 128'(lat));
      armed[i] = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic iv, input logic rr, input bit use_tbl,
                       input logic [13:0] exp, input string name);
    rst = r;
    in_valid = iv;
    rk_ready = rr;
    @(negedge clk);
    check(name, 128'(dut_vec()), 128'(use_tbl ? exp : model_vec()));
    for (int i = 0; i < 3; i++) lat_mon(i);
    @(posedge clk);
    model_step(r, iv, rr);
    if (r) for (int i = 0; i < 3; i++) armed[i] = 1'b0;
    #1;
  endtask

  task automatic run_key(input int stall_at, input int stall_len, input int rst_round,
                         output logic [127:0] rk1, output logic [127:0] rk10,
                         output int idle_at);
    int stalled;
    logic r, rr;
    stalled = 0;
    rk1 = '0;
    rk10 = '0;
    idle_at = -1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0 && x_in_ready[1]) begin
        idle_at = t;
        break;
      end
      r = 1'b0;
      rr = 1'b1;
      if (m_st == MHold && m_round == stall_at && stalled < stall_len) begin
        rr = 1'b0;
        stalled++;
        check("stall_idx", 128'(x_rk_idx[1]), 128'(stall_at));
        check("stall_key_en", 128'(x_key_reg_en[1]), 128'(0));
      end
      if (x_rk_valid[1] && x_rk_idx[1] == 4'd1) rk1 = key_reg;
      if (x_rk_valid[1] && x_rk_idx[1] == 4'd10) rk10 = key_reg;
      if (m_st == MRun && m_round == rst_round && m_k == 2) r = 1'b1;
      cycle(r, t == 0, rr, 1'b0, '0, "outputs");
      if (r) break;
    end
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic       rr;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [14];
  logic [127:0] rk1a, rk10a, rk1b, rk10b;
  int ia, ib;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    rk_ready = 1'b0;
    ext_key = FipsKey;
    for (int i = 0; i < 3; i++) begin
      gap[i] = 0;
      rcnt[i] = 0;
      armed[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    m_st = MIdle;
    m_round = 0;
    m_k = 0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, {FIdle, 4'd0}};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, {FIdle, 4'd0}};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, {FLoad, 4'd0}};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, {FHold, 4'd0}};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, {FFeed, 4'd0}};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, {FWait, 4'd0}};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, {FWait, 4'd0}};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, {FWait, 4'd0}};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, {FUpd,  4'd0}};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, {FHold, 4'd1}};
    tbl[10] = '{1'b0, 1'b1, 1'b0, {FHold, 4'd1}};
    tbl[11] = '{1'b0, 1'b0, 1'b1, {FHold, 4'd1}};
    tbl[12] = '{1'b0, 1'b1, 1'b0, {FFeed, 4'd1}};
    tbl[13] = '{1'b0, 1'b1, 1'b1, {FWait, 4'd1}};
    for (int i = 0; i < 14; i++) begin
      if (i == 9) check("rk1_vec", key_reg, Rk1);
      cycle(tbl[i].rst, tbl[i].iv, tbl[i].rr, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));
    end
    for (int t = 0; t < 200 && m_st != MIdle; t++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "outputs");

    run_key(-1, 0, -1, rk1a, rk10a, ia);
    check("fips_rk1", rk1a, Rk1);
    check("fips_rk10", rk10a, Rk10);
    check("accept_to_ready", 128'(ia), 128'(2 + N * (L + 2) + 1));

    run_key(3, 7, -1, rk1b, rk10b, ib);
    check("stall_rk10", rk10b, rk10a);
    check("stall_accept_to_ready", 128'(ib), 128'(2 + N * (L + 2) + 1 + 7));

    run_key(-1, 0, 5, rk1b, rk10b, ib);
    check("rst_in_ready", 128'(x_in_ready[1]), 128'(1));
    check("rst_rk_idx", 128'(x_rk_idx[1]), 128'(0));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, "outputs");
    check("rst_rcon_init", 128'(rcon), 128'h01);
    run_key(-1, 0, -1, rk1b, rk10b, ib);
    check("rst_rk1", rk1b, Rk1);
    check("rst_rk10", rk10b, Rk10);

    for (int t = 0; t < 3000; t++) begin
      ext_key = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(199) == 0, 1'($urandom_range(1)), $urandom_range(9) < 7, 1'b0, '0,
            "outputs");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
